sequence_receiver: RTL and testbench
====================================

# sequence_receiver

Serial-to-parallel receiver for the 8-bit repeating sequence produced by the sequencer block, which transmits din[0] first. It shifts in the serial stream ds and hunts for a programmable 8-bit pattern at any bit offset. Once the pattern repeats on consecutive 8-bit boundaries it declares frame lock, then delivers each received word in parallel with a match/error indication. It sits at the far end of the serial link, on the same clk as the transmitter.

## Interface
Parameters:
- LOCK_CNT, 3: consecutive aligned matches, including the first, required to lock (legal range 1..7).
- UNLOCK_CNT, 2: consecutive aligned mismatches while locked that drop lock (legal range 1..7).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clrn  input  1  reset; asynchronous, active-low.
- en  input  1  bit enable; one serial bit is sampled per edge with en=1.
- ds  input  1  serial data; LSB of each word first.
- pattern  input  8  expected word; must be held stable during operation.
- dout  output  8  last word delivered at a boundary while locked.
- dout_valid  output  1  one-cycle pulse when dout is loaded.
- match  output  1  one-cycle pulse when an evaluated window equals pattern.
- locked  output  1  level; high in state LOCKED.
- err_cnt  output  8  saturating count of mismatched words while locked.

## Operation
- Shift register: on each edge with en=1, shreg <= {ds, shreg[7:1]}. After 8 bits, shreg[0] holds the first-received bit.
- Window: the next value of shreg, {ds, shreg[7:1]}. It is evaluated on the same edge, so all flags are registered from that edge.
- fill: counts 0..8 and saturates. In HUNT, no window is evaluated until fill reaches 8, counting the current bit. fill is not cleared when lock is lost.
- phase: 3-bit bit counter. It is cleared to 0 on the edge that starts alignment. A boundary is the edge on which phase goes from 7 to 0, i.e. every 8th enabled bit after alignment.
- HUNT:
  - The window is evaluated every enabled edge once fill is full.
  - On a match: pulse match, clear phase, set cnt=1.
  - If LOCK_CNT=1, go straight to LOCKED; this counts as a locking boundary. Otherwise go to CONFIRM.
- CONFIRM:
  - The window is evaluated only at boundaries.
  - On a match: pulse match, increment cnt. When cnt reaches LOCK_CNT, go to LOCKED.
  - On a mismatch: go to HUNT with no match pulse. Evaluation restarts on the next enabled edge.
- LOCKED:
  - At every boundary, and on the locking boundary itself: load dout with the window and pulse dout_valid.
  - On a match: pulse match and clear miss.
  - On a mismatch: increment err_cnt (saturates at 255) and increment miss.
  - When miss reaches UNLOCK_CNT, go to HUNT, drop locked, and clear miss. dout keeps its value.
- en=0: all state frozen, and match and dout_valid are 0 for that cycle.
- Self-similar patterns (e.g. 0xFF, 0x55) may match at the first qualifying offset. This is correct behaviour, since the stream is periodic in that offset.

## Timing
- Reset values: shreg=0, fill=0, phase=0, cnt=0, miss=0, state=HUNT; dout=0x00, dout_valid=0, match=0, locked=0, err_cnt=0x00.
- Latency: the bit sampled at edge k completes a window; match, dout and dout_valid are visible from edge k until edge k+1.
- locked rises on the edge of the LOCK_CNT-th aligned match and falls on the edge of the UNLOCK_CNT-th consecutive miss.
- Reset asserted mid-word or while locked: every register returns to its reset value immediately, with no clock needed.
- Simultaneous events on one edge:
  - A mismatch that drops lock still pulses dout_valid and increments err_cnt on that edge.
  - err_cnt at 255 holds at 255.

## Structure
- Shared package sequence_rx_pkg:
  - state enum {HUNT, CONFIRM, LOCKED};
  - WORD_W=8;
  - PHASE_W=3.
- One sub-module, bit_phase_counter: 3-bit counter with en, synchronous clear, asynchronous clrn, and a wrap output that goes high when phase=7 and en=1.
- Shift register, fill counter, FSM and output registers live in the top level.

## Test plan
- Reset: with clrn=0 mid-stream, all outputs read 0 asynchronously. After release with en=0, nothing changes.
- Basic lock: drive the generator stream for pattern=0xB2 (bits 0,1,0,0,1,1,0,1 repeating) with en=1.
  - match pulses at bits 8, 16 and 24.
  - locked rises at bit 24, where dout=0xB2 and dout_valid pulses.
  - dout_valid then pulses every 8 bits.
- Offset acquisition: precede the same stream with 3 junk bits. First match at bit 11, locked at bit 27.
- Single error: while locked, flip one bit of one word.
  - At that boundary dout shows the corrupted word, there is no match pulse and err_cnt=1.
  - locked stays high.
- Loss of lock: corrupt 2 consecutive words.
  - err_cnt=2 and locked falls at the second boundary.
  - Re-lock occurs 3 aligned matches later.
- Gated enable: insert random en=0 cycles into the basic-lock stream. Lock bit indices are unchanged when counted in enabled bits.

Source files
------------

// File: rtl/sequence_rx_pkg.sv
// sequence_rx_pkg: shared types and widths for the sequence receiver
package sequence_rx_pkg;
  localparam int WORD_W = 8;
  localparam int PHASE_W = 3;
  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return v + WORD_W'(v != '1);
  endfunction
endpackage

// File: rtl/bit_phase_counter.sv
// bit_phase_counter: free-running bit phase within a word, wrap marks a word boundary
module bit_phase_counter
  import sequence_rx_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic clr,
  output logic wrap
);
  logic [PHASE_W-1:0] phase;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) phase <= '0;
    else if (clr) phase <= '0;
    else if (en) phase <= phase + PHASE_W'(1);
  assign wrap = en && (&phase);
endmodule

// File: rtl/sequence_receiver.sv
// sequence_receiver: hunts for a repeating 8-bit pattern in a serial stream, locks and delivers words
module sequence_receiver
  import sequence_rx_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int UNLOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              en,
  input  logic              ds,
  input  logic [WORD_W-1:0] pattern,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              match,
  output logic              locked,
  output logic [WORD_W-1:0] err_cnt
);
  localparam logic [2:0] LC = 3'(LOCK_CNT);
  localparam logic [2:0] UC = 3'(UNLOCK_CNT);
  state_t state, state_n;
  logic [WORD_W-1:0] shreg, win, dout_n, err_n;
  logic [3:0] fill;
  logic [2:0] cnt, cnt_n, miss, miss_n;
  logic wrap, hit, clr, match_n, dv_n;
  assign win = {ds, shreg[WORD_W-1:1]};
  assign hit = win == pattern;
  assign locked = state == LOCKED;
  bit_phase_counter u_phase (.clk(clk), .clrn(clrn), .en(en), .clr(clr), .wrap(wrap));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    miss_n = miss;
    err_n = err_cnt;
    dout_n = dout;
    match_n = 1'b0;
    dv_n = 1'b0;
    clr = 1'b0;
    if (en)
      case (state)
        HUNT:
          if (fill >= 4'd7 && hit) begin
            match_n = 1'b1;
            clr = 1'b1;
            cnt_n = 3'd1;
            state_n = LC == 3'd1 ? LOCKED : CONFIRM;
            dv_n = LC == 3'd1;
            dout_n = LC == 3'd1 ? win : dout;
          end
        CONFIRM:
          if (wrap) begin
            if (hit) begin
              match_n = 1'b1;
              cnt_n = cnt + 3'd1;
              if (cnt_n == LC) begin
                state_n = LOCKED;
                dv_n = 1'b1;
                dout_n = win;
              end
            end else state_n = HUNT;
          end
        LOCKED:
          if (wrap) begin
            dv_n = 1'b1;
            dout_n = win;
            if (hit) begin
              match_n = 1'b1;
              miss_n = '0;
            end else begin
              err_n = sat_inc(err_cnt);
              miss_n = miss + 3'd1;
              if (miss_n == UC) begin
                state_n = HUNT;
                miss_n = '0;
              end
            end
          end
        default: state_n = HUNT;
      endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= HUNT;
      shreg <= '0;
      fill <= '0;
      cnt <= '0;
      miss <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      match <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      miss <= miss_n;
      dout <= dout_n;
      dout_valid <= dv_n;
      match <= match_n;
      err_cnt <= err_n;
      if (en) begin
        shreg <= win;
        fill <= fill + 4'(fill != 4'd8);
      end
    end
endmodule

// File: tb/tb_sequence_receiver.sv
// tb_sequence_receiver: directed checks of hunt, lock, errors, unlock, gating and reset
module tb_sequence_receiver;
  logic clk = 1'b0, clrn = 1'b0, en = 1'b0, ds = 1'b0;
  logic [7:0] pattern = 8'hB2;
  logic [7:0] dout, err_cnt;
  logic dout_valid, match, locked;
  int checks = 0, failures = 0;
  sequence_receiver dut (
    .clk(clk), .clrn(clrn), .en(en), .ds(ds), .pattern(pattern),
    .dout(dout), .dout_valid(dout_valid), .match(match), .locked(locked), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic b, input logic e);
    @(negedge clk);
    ds = b;
    en = e;
    @(posedge clk);
    #1;
  endtask
  task automatic word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) tick(w[k], 1'b1);
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dv"}, dout_valid, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err_cnt, 0);
  endtask
  task automatic reset_pulse();
    @(negedge clk);
    clrn = 1'b0;
    #1 clrn = 1'b1;
  endtask
  initial begin
    // reset held while bits stream in, then released with en low
    for (int i = 0; i < 4; i++) tick(i[0], 1'b1);
    all_zero("rst_hold");
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 4; i++) tick(~i[0], 1'b0);
    all_zero("rst_idle");
    // basic lock from bit 1
    for (int i = 1; i <= 40; i++) begin
      tick(pattern[(i - 1) % 8], 1'b1);
      check($sformatf("lock_match_%0d", i), match, i % 8 == 0);
      check($sformatf("lock_locked_%0d", i), locked, i >= 24);
      check($sformatf("lock_dv_%0d", i), dout_valid, i >= 24 && i % 8 == 0);
      if (i == 24) check("lock_dout", dout, 8'hB2);
    end
    // asynchronous reset while locked, no clock edge in between
    @(negedge clk);
    #2 clrn = 1'b0;
    #1 all_zero("rst_async");
    @(negedge clk);
    clrn = 1'b1;
    // offset acquisition after 3 junk bits
    for (int i = 1; i <= 27; i++) begin
      tick(i <= 3 ? 1'b1 : pattern[(i - 4) % 8], 1'b1);
      check($sformatf("off_match_%0d", i), match, i == 11 || i == 19 || i == 27);
      check($sformatf("off_locked_%0d", i), locked, i >= 27);
    end
    check("off_dout", dout, 8'hB2);
    // single corrupted word keeps lock
    word(8'hB3);
    check("err1_dout", dout, 8'hB3);
    check("err1_match", match, 0);
    check("err1_dv", dout_valid, 1);
    check("err1_cnt", err_cnt, 1);
    check("err1_locked", locked, 1);
    word(8'hB2);
    check("ok_match", match, 1);
    check("ok_cnt", err_cnt, 1);
    // two consecutive corrupted words drop lock
    word(8'h32);
    check("loss1_cnt", err_cnt, 2);
    check("loss1_locked", locked, 1);
    word(8'h32);
    check("loss2_cnt", err_cnt, 3);
    check("loss2_locked", locked, 0);
    check("loss2_dv", dout_valid, 1);
    check("loss2_dout", dout, 8'h32);
    // re-lock after three aligned matches
    word(8'hB2);
    check("relock1_match", match, 1);
    check("relock1_locked", locked, 0);
    word(8'hB2);
    check("relock2_match", match, 1);
    check("relock2_locked", locked, 0);
    word(8'hB2);
    check("relock3_locked", locked, 1);
    check("relock3_dv", dout_valid, 1);
    check("relock3_dout", dout, 8'h32 ^ 8'h80);
    // alternating bad/good words drive err_cnt into saturation without losing lock
    for (int p = 0; p < 252; p++) begin
      word(8'hB3);
      word(8'hB2);
    end
    check("sat_reach", err_cnt, 255);
    check("sat_locked", locked, 1);
    for (int p = 0; p < 8; p++) begin
      word(8'hB3);
      word(8'hB2);
    end
    check("sat_hold", err_cnt, 255);
    // gated enable: lock indices counted in enabled bits
    reset_pulse();
    all_zero("rst_gate");
    for (int i = 1; i <= 32; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        tick(1'($urandom), 1'b0);
        check($sformatf("gate_idle_match_%0d", i), match, 0);
        check($sformatf("gate_idle_dv_%0d", i), dout_valid, 0);
        check($sformatf("gate_idle_locked_%0d", i), locked, i > 24);
      end
      tick(pattern[(i - 1) % 8], 1'b1);
      check($sformatf("gate_match_%0d", i), match, i % 8 == 0);
      check($sformatf("gate_locked_%0d", i), locked, i >= 24);
      check($sformatf("gate_dv_%0d", i), dout_valid, i >= 24 && i % 8 == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
